// File: rtl/krnl_rtl_trial_a_example_number_checker_if.sv
// AXI4-Stream channel carrying the adder results into the number checker.
// The master modport drives the data and the slave modport returns tready.
interface krnl_rtl_trial_a_example_number_checker_if #(
    parameter int DATA_WIDTH = 512
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/krnl_rtl_trial_a_example_number_checker.sv
// Self-test stream sink: checks every lane against beat*LANES + lane + constant,
// counts bad beats and tlast framing errors, then reports pass/done.
module krnl_rtl_trial_a_example_number_checker #(
    parameter int C_S_AXIS_TDATA_WIDTH = 512,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_IN_BYTES    = 16384,
    parameter int C_ERR_CNT_WIDTH      = 16,
    localparam int NUM_BEATS = C_LENGTH_IN_BYTES / (C_S_AXIS_TDATA_WIDTH / 8),
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [C_NUMBER_BIT_WIDTH-1:0] ctrl_constant,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    output logic                          pass,
    output logic [C_ERR_CNT_WIDTH-1:0]    err_count,
    output logic [BEAT_W-1:0]             first_err_beat,
    output logic                          tlast_err,
    krnl_rtl_trial_a_example_number_checker_if.slave s_axis
);
    localparam int NW      = C_NUMBER_BIT_WIDTH;
    localparam int DW      = C_S_AXIS_TDATA_WIDTH;
    localparam int KW      = DW / 8;
    localparam int LANES   = DW / NW;
    localparam int LANE_KW = NW / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic                tready;
    logic                accept;
    logic                start_ok;
    logic [NW-1:0]       const_q;
    logic [BEAT_W-1:0]   beat_cnt;

    // Stage-1 capture of the accepted beat
    logic                s1_valid;
    logic [DW-1:0]       s1_data;
    logic [KW-1:0]       s1_keep;
    logic                s1_last;
    logic [BEAT_W-1:0]   s1_beat;

    logic [NW-1:0]       lane_base;
    logic [LANE_KW-1:0]  lane_keep;
    logic                beat_bad;

    assign s_axis.tready = tready;
    assign accept        = s_axis.tvalid && tready;
    assign start_ok      = (state == S_IDLE) && ap_start;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        tready    = 1'b0;
        ap_idle   = 1'b0;
        unique case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = S_RUN;
            end
            S_RUN: begin
                tready = 1'b1;
                if (s_axis.tvalid && beat_cnt == LAST_BEAT) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A lane is good when fully kept and equal to its expected number, or fully masked.
    always_comb begin
        beat_bad  = 1'b0;
        lane_keep = '0;
        lane_base = NW'(s1_beat) * NW'(LANES) + const_q;
        for (int i = 0; i < LANES; i++) begin
            lane_keep = s1_keep[i*LANE_KW +: LANE_KW];
            if (&lane_keep) begin
                if (s1_data[i*NW +: NW] != lane_base + NW'(i)) beat_bad = 1'b1;
            end else if (|lane_keep) begin
                beat_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            const_q        <= '0;
            beat_cnt       <= '0;
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            s1_keep        <= '0;
            s1_last        <= 1'b0;
            s1_beat        <= '0;
            err_count      <= '0;
            first_err_beat <= '0;
            tlast_err      <= 1'b0;
            pass           <= 1'b0;
            ap_done        <= 1'b0;
        end else begin
            ap_done  <= (state == S_DONE);
            s1_valid <= accept;

            if (accept) begin
                s1_data  <= s_axis.tdata;
                s1_keep  <= s_axis.tkeep;
                s1_last  <= s_axis.tlast;
                s1_beat  <= beat_cnt;
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end

            if (start_ok) begin
                const_q        <= ctrl_constant;
                beat_cnt       <= '0;
                err_count      <= '0;
                first_err_beat <= '0;
                tlast_err      <= 1'b0;
                pass           <= 1'b0;
            end else if (s1_valid) begin
                if (beat_bad) begin
                    // err_count only leaves zero on the first bad beat, so it doubles as the "seen" flag
                    if (err_count == '0) first_err_beat <= s1_beat;
                    if (err_count != '1) err_count <= err_count + 1'b1;
                end
                if (s1_last != (s1_beat == LAST_BEAT)) tlast_err <= 1'b1;
            end

            if (state == S_DONE) pass <= (err_count == '0) && !tlast_err;
        end
    end
endmodule

// File: tb/tb_krnl_rtl_trial_a_example_number_checker.sv
// Directed bench for the number checker: correct, wrapped, corrupted, mis-framed,
// keep-masked and reset-aborted streams, each checked with immediate assertions.
module tb_krnl_rtl_trial_a_example_number_checker;
    localparam int DW        = 512;
    localparam int NW        = 32;
    localparam int LANES     = DW / NW;
    localparam int NUM_BEATS = 256;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] ctrl_constant;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        pass;
    logic [15:0] err_count;
    logic [7:0]  first_err_beat;
    logic        tlast_err;

    krnl_rtl_trial_a_example_number_checker_if #(.DATA_WIDTH(DW)) s_axis ();

    krnl_rtl_trial_a_example_number_checker dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .ctrl_constant  (ctrl_constant),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_beat (first_err_beat),
        .tlast_err      (tlast_err),
        .s_axis         (s_axis)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    // Stream shaping controls; -1 disables a control
    int          bad_beat0  = -1;
    int          bad_lane0  = 0;
    int          bad_beat1  = -1;
    int          bad_lane1  = 0;
    int          keep_beat  = -1;
    logic [63:0] keep_val   = '1;
    int          tlast_beat = NUM_BEATS - 1;
    int          abort_at   = -1;
    int          accepted   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ap_done", 32'(ap_done), 0);
        check("rst_ap_idle", 32'(ap_idle), 1);
        check("rst_tready", 32'(s_axis.tready), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_first_err_beat", 32'(first_err_beat), 0);
        check("rst_tlast_err", 32'(tlast_err), 0);
    endtask

    task automatic clear_shaping();
        bad_beat0  = -1;
        bad_beat1  = -1;
        keep_beat  = -1;
        keep_val   = '1;
        tlast_beat = NUM_BEATS - 1;
        abort_at   = -1;
    endtask

    task automatic drive_beat(input int b, input logic [31:0] c);
        logic [DW-1:0]   d;
        logic [DW/8-1:0] k;
        k = (b == keep_beat) ? keep_val : '1;
        for (int i = 0; i < LANES; i++) begin
            d[i*NW +: NW] = (k[i*4 +: 4] == 4'h0) ? 32'hDEAD_BEEF : 32'(b * LANES + i) + c;
            if ((b == bad_beat0 && i == bad_lane0) || (b == bad_beat1 && i == bad_lane1))
                d[i*NW +: NW] = d[i*NW +: NW] ^ 32'h0000_0100;
        end
        s_axis.tdata = d;
        s_axis.tkeep = k;
        s_axis.tlast = (b == tlast_beat);
    endtask

    task automatic start_run(input logic [31:0] c);
        @(negedge aclk);
        ctrl_constant = c;
        ap_start      = 1'b1;
        check("idle_before_start", 32'(ap_idle), 1);
        check("tready_in_idle", 32'(s_axis.tready), 0);
        @(negedge aclk);
        ap_start      = 1'b0;
        // The constant is latched at start; changing it now must not matter
        ctrl_constant = 32'h0BAD_0BAD;
        check("pass_cleared_on_start", 32'(pass), 0);
    endtask

    task automatic send_stream(input logic [31:0] c, input bit gaps);
        int   cycles = 0;
        logic hs;
        accepted = 0;
        while (accepted < NUM_BEATS && accepted != abort_at && cycles < 4000) begin
            @(negedge aclk);
            drive_beat(accepted, c);
            s_axis.tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            hs = s_axis.tvalid && s_axis.tready;
            @(posedge aclk);
            cycles++;
            if (hs) accepted++;
        end
        check("stream_within_budget", 32'(cycles < 4000), 1);
    endtask

    // Last handshake edge is E0; DRAIN follows, then DONE, then the ap_done pulse.
    task automatic finish_stream(input int exp_err, input int exp_first, input int exp_tlast, input int exp_pass);
        @(negedge aclk);
        s_axis.tvalid = 1'b0;
        check("tready_in_drain", 32'(s_axis.tready), 0);
        check("no_done_in_drain", 32'(ap_done), 0);
        @(negedge aclk);
        check("tready_in_done", 32'(s_axis.tready), 0);
        check("no_done_before_latency", 32'(ap_done), 0);
        check("beats_accepted", 32'(accepted), NUM_BEATS);
        @(negedge aclk);
        check("ap_done_at_3", 32'(ap_done), 1);
        check("err_count", 32'(err_count), 32'(exp_err));
        check("first_err_beat", 32'(first_err_beat), 32'(exp_first));
        check("tlast_err", 32'(tlast_err), 32'(exp_tlast));
        check("pass", 32'(pass), 32'(exp_pass));
        @(negedge aclk);
        check("ap_done_one_cycle", 32'(ap_done), 0);
        check("pass_holds", 32'(pass), 32'(exp_pass));
        check("idle_after_done", 32'(ap_idle), 1);
    endtask

    initial begin
        int done_seen;
        aresetn       = 1'b0;
        ap_start      = 1'b0;
        ctrl_constant = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // Correct stream, constant 5, no gaps
        start_run(32'd5);
        send_stream(32'd5, 1'b0);
        finish_stream(0, 0, 0, 1);

        // Lanes wrap through zero, random tvalid gaps
        start_run(32'hFFFF_FFF8);
        send_stream(32'hFFFF_FFF8, 1'b1);
        finish_stream(0, 0, 0, 1);

        // Two corrupted lanes
        bad_beat0 = 10;  bad_lane0 = 3;
        bad_beat1 = 200; bad_lane1 = 0;
        start_run(32'h0000_1234);
        send_stream(32'h0000_1234, 1'b0);
        finish_stream(2, 10, 0, 0);
        clear_shaping();

        // Early tlast on beat 100, none on the final beat
        tlast_beat = 100;
        start_run(32'd9);
        send_stream(32'd9, 1'b1);
        finish_stream(0, 0, 1, 0);
        clear_shaping();

        // Upper lanes masked with garbage data: skipped
        keep_beat = 7; keep_val = 64'h0000_0000_0000_00FF;
        start_run(32'd77);
        send_stream(32'd77, 1'b0);
        finish_stream(0, 0, 0, 1);

        // Lane 0 partially kept: bad beat
        keep_beat = 20; keep_val = 64'h0000_0000_0000_0003;
        start_run(32'd77);
        send_stream(32'd77, 1'b0);
        finish_stream(1, 20, 0, 0);
        clear_shaping();

        // Reset at beat 50 abandons the check
        bad_beat0 = 10; bad_lane0 = 3;
        abort_at  = 50;
        start_run(32'd3);
        send_stream(32'd3, 1'b0);
        @(negedge aclk);
        check("err_before_abort", 32'(err_count), 1);
        check("first_err_before_abort", 32'(first_err_beat), 10);
        aresetn = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge aclk);
        aresetn       = 1'b1;
        s_axis.tvalid = 1'b0;
        done_seen     = 0;
        repeat (300) begin
            @(negedge aclk);
            if (ap_done) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 0);
        check("idle_after_reset", 32'(ap_idle), 1);
        clear_shaping();

        // Fresh run after the abort
        start_run(32'd7);
        send_stream(32'd7, 1'b0);
        finish_stream(0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
